byte_word_packer: RTL and testbench
===================================

Name: byte_word_packer

Overview:
Downstream stage of the 16-bit word slicer. Consumes its 8-bit byte stream and repacks byte pairs into 16-bit words for the next word-wide consumer. Valid/ready handshake on both sides. Small output FIFO decouples backpressure.

Parameters:
OUT_DEPTH, 2, output FIFO depth in words (power of two, >= 2)
FIRST_HIGH, 1, 1: first byte of a pair lands in word[15:8]; 0: in word[7:0]
PAD_BYTE, 8'h00, fill byte for flushed half-words (optional feature only)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
in_byte  input  8  byte from slicer stage
in_valid  input  1  in_byte valid
in_ready  output  1  packer accepts in_byte this cycle
out_word  output  16  packed word (FIFO head)
out_valid  output  1  out_word valid
out_ready  input  1  consumer accepts out_word this cycle
half_full  output  1  one byte held, waiting for its partner
flush  input  1  (PACKER_FLUSH_EN only) emit held byte as padded word
out_padded  output  1  (PACKER_FLUSH_EN only) out_word low/high half is PAD_BYTE

Behaviour:
- Clock and reset: single clock clk; rst synchronous, active-high, sampled on rising edge.
- Reset values: state=EMPTY, hold=8'h00, FIFO count=0, out_valid=0, out_word=16'h0000, half_full=0, in_ready=1 from the first cycle after reset, out_padded=0.
- Byte accept: in_valid && in_ready. Word pop: out_valid && out_ready.
- FSM, two states:
  - EMPTY: accept -> hold<=in_byte, go HALF. No FIFO push.
  - HALF: accept -> push word, go EMPTY. Word = {hold,in_byte} if FIRST_HIGH=1, else {in_byte,hold}.
- half_full = (state==HALF).
- in_ready = (state==EMPTY) || (count < OUT_DEPTH). Registered inputs only; no combinational path from out_ready to in_ready. A pop in the same cycle does not free space for a push.
- FIFO: push and pop in the same cycle -> count unchanged, order preserved. out_valid = (count!=0). out_word is the head entry, driven from registers, and is stable while out_valid && !out_ready.
- Latency: word appears on out_valid the cycle after its second byte is accepted. Sustained throughput is 1 byte/cycle in, 1 word per 2 cycles out.
- Full, state EMPTY: bytes still accepted (go HALF).
- Full, state HALF: in_ready=0 until a pop.
- Pointers wrap modulo OUT_DEPTH. Count is width clog2(OUT_DEPTH)+1.
- rst mid-stream: the held byte and all FIFO contents are discarded, with no partial output.
- in_byte is ignored when in_valid=0. Sender must hold in_byte/in_valid until accepted; the packer does not check this.

Optional Feature:
- Macro: PACKER_FLUSH_EN.
- When defined:
  - flush and out_padded ports exist; FIFO entries are 17 bits (padded flag + word).
  - In HALF with flush=1, no byte accepted that cycle, and count<OUT_DEPTH: push the hold byte paired with PAD_BYTE, in FIRST_HIGH ordering, with flag=1; go EMPTY.
  - In HALF, a byte accept in the same cycle as flush takes precedence and forms a normal word; flush is ignored.
  - In EMPTY, flush is a no-op.
  - With the FIFO full, flush waits; it is level-sensitive, so the requester holds it.
- When undefined: neither port exists and the FIFO is 16 bits.

Decomposition:
- Package byte_packer_pkg:
  - byte_t (8-bit), word_t (16-bit)
  - pack_state_e {EMPTY, HALF}
  - entry_t (word_t plus padded flag, under PACKER_FLUSH_EN)
  - default PAD_BYTE constant
- One sub-module, word_fifo: synchronous FIFO parameterised by DEPTH and entry width; ports push/pop/full/empty/count/head.
- FSM and hold register stay in byte_word_packer.

Test Plan:
- Bytes 8'hAB, 8'hCD back-to-back, out_ready=1, FIRST_HIGH=1 -> out_word=16'hABCD, out_valid one cycle after the 8'hCD accept; half_full high exactly one cycle.
- Same stimulus with FIRST_HIGH=0 -> out_word=16'hCDAB.
- out_ready=0; send 8'h01..8'h06 -> words 16'h0102, 16'h0304 queued. 8'h05 accepted (half_full=1), then in_ready=0 holding 8'h06. Raise out_ready -> 8'h06 accepted the cycle after the first pop. Order is 0102, 0304, 0506.
- Push and pop in the same cycle at count=1 -> count stays 1, no word lost or duplicated, over 100 random bytes against a scoreboard.
- Send 8'h11 then assert rst for one cycle -> next pair 8'h22, 8'h33 yields 16'h2233, not containing 8'h11. All outputs at reset values during rst.
- PACKER_FLUSH_EN, PAD_BYTE=8'hFF: send 8'h5A, then flush -> out_word=16'h5AFF with out_padded=1.
- PACKER_FLUSH_EN: flush together with the second byte 8'h77 -> 16'h5A77 with out_padded=0.

Source files
------------

// File: rtl/byte_word_packer_pkg.sv
// Shared types and helpers for the byte-to-word packer.
// Optional feature macro: PACKER_FLUSH_EN adds a padded flag to each queued entry.
package byte_packer_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic [15:0] word_t;

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } pack_state_e;

`ifdef PACKER_FLUSH_EN
  typedef struct packed {
    logic  padded;
    word_t word;
  } entry_t;
`else
  typedef struct packed {
    word_t word;
  } entry_t;
`endif

  localparam byte_t PAD_BYTE_DEFAULT = 8'h00;

  // Place the first byte of a pair in the high or low half of the word.
  function automatic word_t pack_word(byte_t first, byte_t second, bit first_high);
    return first_high ? {first, second} : {second, first};
  endfunction

endpackage

// File: rtl/byte_word_packer_if.sv
// Byte-in / word-out handshake bundle of the packer.
// master: byte producer + word consumer side; slave: the packer.
// Optional feature macro: PACKER_FLUSH_EN adds flush and out_padded.
interface byte_word_packer_if;
  import byte_packer_pkg::*;

  byte_t in_byte;
  logic  in_valid;
  logic  in_ready;
  word_t out_word;
  logic  out_valid;
  logic  out_ready;
  logic  half_full;
`ifdef PACKER_FLUSH_EN
  logic  flush;
  logic  out_padded;

  modport master (
    output in_byte, in_valid, out_ready, flush,
    input  in_ready, out_word, out_valid, half_full, out_padded
  );

  modport slave (
    input  in_byte, in_valid, out_ready, flush,
    output in_ready, out_word, out_valid, half_full, out_padded
  );
`else
  modport master (
    output in_byte, in_valid, out_ready,
    input  in_ready, out_word, out_valid, half_full
  );

  modport slave (
    input  in_byte, in_valid, out_ready,
    output in_ready, out_word, out_valid, half_full
  );
`endif

endinterface

// File: rtl/byte_word_packer_fifo.sv
// Synchronous FIFO holding packed entries; head is read straight from storage.
// Ports: clk, rst (sync, active-high), push/push_data, pop, full, empty, count, head.
// DEPTH must be a power of two >= 2 so pointers wrap naturally.
module word_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_q;
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy; simultaneous push+pop keeps count.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/byte_word_packer.sv
// Packs pairs of bytes into 16-bit words behind a small output FIFO.
// Ports: clk, rst (sync, active-high), bus (slave modport: in_byte/in_valid/
// in_ready, out_word/out_valid/out_ready, half_full[, flush, out_padded]).
// Optional feature macro: PACKER_FLUSH_EN (flush a lone held byte padded with PAD_BYTE).
module byte_word_packer
  import byte_packer_pkg::*;
#(
  parameter int unsigned OUT_DEPTH  = 2,
  parameter bit          FIRST_HIGH = 1'b1
`ifdef PACKER_FLUSH_EN
  ,
  parameter byte_t       PAD_BYTE   = PAD_BYTE_DEFAULT
`endif
) (
  input  logic                clk,
  input  logic                rst,
  byte_word_packer_if.slave   bus
);

  localparam int unsigned CW = $clog2(OUT_DEPTH) + 1;

  pack_state_e   state_q, state_d;
  byte_t         hold_q, hold_d;
  logic          fifo_push;
  entry_t        push_entry;
  entry_t        fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          pop;

  // Only registered state feeds in_ready; a same-cycle pop never frees space.
  assign bus.in_ready  = (state_q == EMPTY) || (fifo_count < CW'(OUT_DEPTH));
  assign bus.half_full = (state_q == HALF);
  assign bus.out_valid = !fifo_empty;
  assign bus.out_word  = fifo_head.word;
`ifdef PACKER_FLUSH_EN
  assign bus.out_padded = fifo_head.padded;
`endif
  assign pop = !fifo_empty && bus.out_ready;

  // State and held byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      hold_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Next state, hold capture and FIFO push.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    fifo_push  = 1'b0;
    push_entry = '0;
    case (state_q)
      EMPTY: begin
        // in_ready is always high here, so in_valid alone means accept.
        if (bus.in_valid) begin
          hold_d  = bus.in_byte;
          state_d = HALF;
        end
      end
      HALF: begin
        if (bus.in_valid && !fifo_full) begin
          fifo_push       = 1'b1;
          push_entry.word = pack_word(hold_q, bus.in_byte, FIRST_HIGH);
          state_d         = EMPTY;
        end
`ifdef PACKER_FLUSH_EN
        else if (bus.flush && !fifo_full) begin
          fifo_push         = 1'b1;
          push_entry.word   = pack_word(hold_q, PAD_BYTE, FIRST_HIGH);
          push_entry.padded = 1'b1;
          state_d           = EMPTY;
        end
`endif
      end
      default: state_d = EMPTY;
    endcase
  end

  word_fifo #(
    .DEPTH (OUT_DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

endmodule

// File: tb/tb_byte_word_packer.sv
// Randomised bench for byte_word_packer: two instances (FIRST_HIGH=1 and 0)
// share stimulus and are compared every cycle with a pair-queue reference model.
module tb_byte_word_packer;
  import byte_packer_pkg::*;

  localparam int DEPTH = 2;
  localparam logic [7:0] PAD = 8'hFF;

  typedef struct {
    logic [7:0] first;
    logic [7:0] second;
    logic       pad;
  } pair_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  iv = 1'b0;
  byte_t ib = 8'h00;
  logic  ordy = 1'b0;
  logic  fl = 1'b0;

  always #5 clk = ~clk;

  byte_word_packer_if bus_hi ();
  byte_word_packer_if bus_lo ();

  assign bus_hi.in_byte   = ib;
  assign bus_hi.in_valid  = iv;
  assign bus_hi.out_ready = ordy;
  assign bus_lo.in_byte   = ib;
  assign bus_lo.in_valid  = iv;
  assign bus_lo.out_ready = ordy;
`ifdef PACKER_FLUSH_EN
  assign bus_hi.flush = fl;
  assign bus_lo.flush = fl;
`endif

  byte_word_packer #(
    .OUT_DEPTH  (DEPTH),
    .FIRST_HIGH (1'b1)
`ifdef PACKER_FLUSH_EN
    , .PAD_BYTE (PAD)
`endif
  ) dut_hi (
    .clk (clk),
    .rst (rst),
    .bus (bus_hi.slave)
  );

  byte_word_packer #(
    .OUT_DEPTH  (DEPTH),
    .FIRST_HIGH (1'b0)
`ifdef PACKER_FLUSH_EN
    , .PAD_BYTE (PAD)
`endif
  ) dut_lo (
    .clk (clk),
    .rst (rst),
    .bus (bus_lo.slave)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: a lone pending byte plus a queue of completed pairs.
  bit         m_half = 1'b0;
  logic [7:0] m_hold = 8'h00;
  pair_t      m_q[$];
  bit         m_word_zero = 1'b1;
  bit         last_acc = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic exp_ready;
    exp_ready = !m_half || (m_q.size() < DEPTH);
    check_eq("in_ready_hi",  32'(bus_hi.in_ready),  32'(exp_ready));
    check_eq("in_ready_lo",  32'(bus_lo.in_ready),  32'(exp_ready));
    check_eq("out_valid_hi", 32'(bus_hi.out_valid), 32'(m_q.size() != 0));
    check_eq("out_valid_lo", 32'(bus_lo.out_valid), 32'(m_q.size() != 0));
    check_eq("half_full_hi", 32'(bus_hi.half_full), 32'(m_half));
    check_eq("half_full_lo", 32'(bus_lo.half_full), 32'(m_half));
    if (m_q.size() != 0) begin
      check_eq("out_word_hi", 32'(bus_hi.out_word), 32'({m_q[0].first, m_q[0].second}));
      check_eq("out_word_lo", 32'(bus_lo.out_word), 32'({m_q[0].second, m_q[0].first}));
`ifdef PACKER_FLUSH_EN
      check_eq("out_padded_hi", 32'(bus_hi.out_padded), 32'(m_q[0].pad));
      check_eq("out_padded_lo", 32'(bus_lo.out_padded), 32'(m_q[0].pad));
`endif
    end else if (m_word_zero) begin
      check_eq("out_word_rst_hi", 32'(bus_hi.out_word), 32'h0);
      check_eq("out_word_rst_lo", 32'(bus_lo.out_word), 32'h0);
`ifdef PACKER_FLUSH_EN
      check_eq("out_padded_rst_hi", 32'(bus_hi.out_padded), 32'h0);
`endif
    end
  endtask

  task automatic model_update();
    bit    rdy;
    bit    pop;
    bit    push;
    pair_t np;
    if (rst) begin
      m_half = 1'b0;
      m_hold = 8'h00;
      m_q.delete();
      m_word_zero = 1'b1;
      last_acc = 1'b0;
      return;
    end
    rdy  = !m_half || (m_q.size() < DEPTH);
    last_acc = iv && rdy;
    pop  = (m_q.size() != 0) && ordy;
    push = 1'b0;
    np   = '{first: 8'h00, second: 8'h00, pad: 1'b0};
    if (last_acc && !m_half) begin
      m_hold = ib;
      m_half = 1'b1;
    end else if (last_acc) begin
      np = '{first: m_hold, second: ib, pad: 1'b0};
      push = 1'b1;
      m_half = 1'b0;
    end
`ifdef PACKER_FLUSH_EN
    else if (m_half && fl && (m_q.size() < DEPTH)) begin
      np = '{first: m_hold, second: PAD, pad: 1'b1};
      push = 1'b1;
      m_half = 1'b0;
    end
`endif
    if (pop) void'(m_q.pop_front());
    if (push) begin
      m_q.push_back(np);
      m_word_zero = 1'b0;
    end
  endtask

  // One clock: check current outputs, drive new inputs, advance the model.
  task automatic step(input logic r, input logic v, input byte_t b, input logic o, input logic f);
    @(negedge clk);
    check_outputs();
    rst  = r;
    iv   = v;
    ib   = b;
    ordy = o;
    fl   = f;
    @(posedge clk);
    model_update();
  endtask

  task automatic send_byte(input byte_t b, input logic o);
    for (int n = 0; n < 20; n++) begin
      step(1'b0, 1'b1, b, o, 1'b0);
      if (last_acc) return;
    end
    check_eq("send_timeout", 32'h0, 32'h1);
  endtask

  task automatic idle(input int n, input logic o);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'h00, o, 1'b0);
  endtask

  initial begin
    logic  rv;
    byte_t rb;
    logic  rf;

    // Reset, then reset-value checks come from the model.
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    idle(1, 1'b1);

    // Basic pair: AB, CD back-to-back.
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    idle(3, 1'b1);

    // Backpressure: two words queued, third pair stalls on its second byte.
    for (int k = 1; k <= 5; k++) send_byte(8'(k), 1'b0);
    step(1'b0, 1'b1, 8'h06, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h06, 1'b0, 1'b0);
    send_byte(8'h06, 1'b1);
    idle(6, 1'b1);

    // Mid-stream reset discards the held byte.
    send_byte(8'h11, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    idle(3, 1'b1);

`ifdef PACKER_FLUSH_EN
    // Flush of a lone byte, then flush colliding with the partner byte.
    send_byte(8'h5A, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    idle(3, 1'b1);
    send_byte(8'h5A, 1'b1);
    step(1'b0, 1'b1, 8'h77, 1'b1, 1'b1);
    idle(3, 1'b1);
    // Flush while full must wait.
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    send_byte(8'hA3, 1'b0);
    send_byte(8'hA4, 1'b0);
    send_byte(8'hA5, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    idle(5, 1'b1);
`endif

    // Random traffic; a pending byte is held until accepted.
    rv = 1'b0;
    rb = 8'h00;
    for (int i = 0; i < 600; i++) begin
      if (!(rv && !last_acc)) begin
        rv = ($urandom_range(0, 3) != 0);
        rb = 8'($urandom);
      end
      rf = 1'b0;
`ifdef PACKER_FLUSH_EN
      rf = ($urandom_range(0, 4) == 0);
`endif
      step(1'b0, rv, rb, ($urandom_range(0, 3) != 0), rf);
    end
    idle(6, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
